// File: rtl/h14tx_data_island_packer_if.sv
// Packet handshake between the InfoFrame/packet source and the data-island packer.
// One packet = 24-bit header plus four 56-bit subpackets.
interface h14tx_data_island_packer_if;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [23:0]  pkt_header;
    logic [223:0] pkt_body;

    modport master (
        output pkt_valid,
        output pkt_header,
        output pkt_body,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  pkt_header,
        input  pkt_body,
        output pkt_ready
    );
endinterface

// File: rtl/h14tx_data_island_packer.sv
// HDMI 1.4 TX data-island packer: buffers one packet and serialises it,
// with BCH parity, onto the 4-bit TMDS channel payloads over a 32-cycle slot.
package h14tx_pkg;
    typedef enum logic [2:0] {
        PER_CONTROL,
        PER_VIDEO_PREAMBLE,
        PER_VIDEO_GUARD,
        PER_VIDEO_ACTIVE,
        PER_DATA_ISLAND_PREAMBLE,
        PER_DATA_ISLAND_GUARD,
        PER_DATA_ISLAND_ACTIVE
    } period_t;

    typedef logic [3:0] data_t;
endpackage

module h14tx_data_island_packer
    import h14tx_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  period_t                      i_period,
    input  logic                         i_hsync,
    input  logic                         i_vsync,
    h14tx_data_island_packer_if.slave    pkt,
    output data_t [2:0]                  o_data
);

    localparam logic [4:0] HDR_BITS = 5'd24;
    localparam logic [4:0] SP_PAIRS = 5'd28;

    function automatic logic [7:0] f_bch(
        input logic [7:0] ecc,
        input logic       b
    );
        return (ecc >> 1) ^ (((ecc[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
    endfunction

    logic               r_full;
    logic [23:0]        r_hdr;
    logic [223:0]       r_body;
    logic [4:0]         r_cnt;
    logic [23:0]        r_act_hdr;
    logic [223:0]       r_act_body;
    logic [7:0]         r_hecc;
    logic [3:0][7:0]    r_secc;

    logic               w_dia;
    logic               w_on;
    logic               w_slot0;
    logic               w_ready;
    logic               w_xfer;
    logic [23:0]        w_cur_hdr;
    logic [223:0]       w_cur_body;
    logic               w_hdr_bit;
    logic               w_hout;
    logic [7:0]         w_hecc_base;
    logic [7:0]         w_hecc_nxt;
    logic [3:0][55:0]   w_sp;
    logic [3:0]         w_even;
    logic [3:0]         w_odd;
    logic [3:0][7:0]    w_secc_base;
    logic [3:0][7:0]    w_secc_nxt;
    logic [3:0]         w_d1;
    logic [3:0]         w_d2;

    assign w_dia   = (i_period == PER_DATA_ISLAND_ACTIVE);
    assign w_on    = w_dia & ~rst;
    assign w_slot0 = w_dia && (r_cnt == 5'd0);
    assign w_ready = !r_full || w_slot0;
    assign w_xfer  = pkt.pkt_valid && w_ready;

    assign pkt.pkt_ready = w_ready;

    // Slot start reads the buffer directly so cycle 0 has no extra latency.
    always_comb begin
        w_cur_hdr  = r_act_hdr;
        w_cur_body = r_act_body;
        if (r_cnt == 5'd0) begin
            w_cur_hdr  = r_full ? r_hdr  : 24'h0;
            w_cur_body = r_full ? r_body : 224'h0;
        end
    end

    assign w_hdr_bit   = w_cur_hdr[r_cnt];
    assign w_hecc_base = (r_cnt == 5'd0) ? 8'h00 : r_hecc;
    assign w_hecc_nxt  = f_bch(w_hecc_base, w_hdr_bit);
    assign w_hout      = (r_cnt < HDR_BITS) ? w_hdr_bit
                                            : r_hecc[r_cnt[2:0]];

    always_comb begin
        w_sp        = '0;
        w_even      = '0;
        w_odd       = '0;
        w_secc_base = '0;
        w_secc_nxt  = '0;
        w_d1        = '0;
        w_d2        = '0;
        for (int k = 0; k < 4; k++) begin
            w_sp[k]        = w_cur_body[56*k +: 56];
            w_even[k]      = w_sp[k][{r_cnt, 1'b0}];
            w_odd[k]       = w_sp[k][{r_cnt, 1'b1}];
            w_secc_base[k] = (r_cnt == 5'd0) ? 8'h00 : r_secc[k];
            w_secc_nxt[k]  = f_bch(f_bch(w_secc_base[k], w_even[k]),
                                   w_odd[k]);
            if (r_cnt < SP_PAIRS) begin
                w_d1[k] = w_even[k];
                w_d2[k] = w_odd[k];
            end else begin
                w_d1[k] = r_secc[k][{r_cnt[1:0], 1'b0}];
                w_d2[k] = r_secc[k][{r_cnt[1:0], 1'b1}];
            end
        end
    end

    always_comb begin
        o_data[0] = {w_on & (r_cnt != 5'd0), w_on & w_hout,
                     i_vsync, i_hsync};
        o_data[1] = w_on ? w_d1 : 4'h0;
        o_data[2] = w_on ? w_d2 : 4'h0;
    end

    // A load in the consume cycle keeps the buffer full with the new packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_hdr  <= '0;
            r_body <= '0;
        end else if (w_xfer) begin
            r_full <= 1'b1;
            r_hdr  <= pkt.pkt_header;
            r_body <= pkt.pkt_body;
        end else if (w_slot0) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_dia) begin
            r_cnt <= r_cnt + 5'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_hdr  <= '0;
            r_act_body <= '0;
        end else if (w_slot0) begin
            r_act_hdr  <= w_cur_hdr;
            r_act_body <= w_cur_body;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hecc <= '0;
        end else if (w_dia && (r_cnt < HDR_BITS)) begin
            r_hecc <= w_hecc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_secc <= '0;
        end else if (w_dia && (r_cnt < SP_PAIRS)) begin
            r_secc <= w_secc_nxt;
        end
    end

endmodule

// File: tb/tb_h14tx_data_island_packer.sv
// Bench for the data-island packer: queue-based packet model, BCH computed
// from whole packets, every cycle's payload and ready compared.
module tb_h14tx_data_island_packer;
    import h14tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    period_t     period;
    logic        hs;
    logic        vs;
    data_t [2:0] odata;

    h14tx_data_island_packer_if u_if();

    h14tx_data_island_packer dut (
        .clk      (clk),
        .rst      (rst),
        .i_period (period),
        .i_hsync  (hs),
        .i_vsync  (vs),
        .pkt      (u_if.slave),
        .o_data   (odata)
    );

    always #5 clk = ~clk;

    int           vectors = 0;
    int           miscompares = 0;
    logic [247:0] mq[$];
    logic [247:0] cur;
    int           scnt;
    logic         offer;
    logic [23:0]  off_h;
    logic [223:0] off_b;

    function automatic logic [7:0] bch(input logic [55:0] bits,
                                       input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < n; i++)
            e = (e >> 1) ^ (((e[0] ^ bits[i]) == 1'b1) ? 8'h83 : 8'h00);
        return e;
    endfunction

    function automatic logic [11:0] expect_word(input logic [247:0] p,
                                                input int c,
                                                input logic dia,
                                                input logic h,
                                                input logic v);
        logic [23:0]  hd;
        logic [223:0] bd;
        logic [55:0]  sp;
        logic [7:0]   he;
        logic [7:0]   se;
        logic [3:0]   d1;
        logic [3:0]   d2;
        logic         b2;
        hd = p[23:0];
        bd = p[247:24];
        d1 = 4'h0;
        d2 = 4'h0;
        if (!dia) return {8'h00, 2'b00, v, h};
        he = bch({32'h0, hd}, 24);
        b2 = (c < 24) ? hd[c] : he[c-24];
        for (int k = 0; k < 4; k++) begin
            sp = bd[56*k +: 56];
            if (c < 28) begin
                d1[k] = sp[2*c];
                d2[k] = sp[2*c+1];
            end else begin
                se = bch(sp, 56);
                d1[k] = se[2*(c-28)];
                d2[k] = se[2*(c-28)+1];
            end
        end
        return {d2, d1, (c != 0), b2, v, h};
    endfunction

    function automatic logic [223:0] rnd_body();
        logic [223:0] b;
        for (int i = 0; i < 7; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic offer_pkt(input logic [23:0] h, input logic [223:0] b);
        offer = 1'b1;
        off_h = h;
        off_b = b;
    endtask

    task automatic step(input period_t p);
        logic        dia;
        logic        rdy_exp;
        logic [11:0] obs;
        @(negedge clk);
        period = p;
        hs = 1'($urandom);
        vs = 1'($urandom);
        u_if.pkt_valid  = offer;
        u_if.pkt_header = off_h;
        u_if.pkt_body   = off_b;
        #1;
        dia = (p == PER_DATA_ISLAND_ACTIVE);
        rdy_exp = (mq.size() == 0) || (dia && scnt == 0);
        if (dia && scnt == 0)
            cur = (mq.size() > 0) ? mq.pop_front() : '0;
        chk("ready", {11'b0, u_if.pkt_ready}, {11'b0, rdy_exp});
        obs = odata;
        chk($sformatf("data@%0d", scnt), obs,
            expect_word(cur, scnt, dia, hs, vs));
        if (offer && rdy_exp) begin
            mq.push_back({off_b, off_h});
            offer = 1'b0;
        end
        scnt = dia ? (scnt + 1) % 32 : 0;
    endtask

    task automatic do_reset();
        logic [11:0] obs;
        @(negedge clk);
        rst = 1'b1;
        period = PER_CONTROL;
        u_if.pkt_valid = 1'b0;
        hs = 1'($urandom);
        vs = 1'($urandom);
        #1;
        chk("rst_ready", {11'b0, u_if.pkt_ready}, 12'h001);
        obs = odata;
        chk("rst_data", obs, {10'b0, vs, hs});
        mq.delete();
        scnt = 0;
        cur = '0;
        offer = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [223:0] b;
        period = PER_CONTROL;
        hs = 1'b0;
        vs = 1'b0;
        u_if.pkt_valid  = 1'b0;
        u_if.pkt_header = '0;
        u_if.pkt_body   = '0;
        offer = 1'b0;
        off_h = '0;
        off_b = '0;
        scnt = 0;
        cur = '0;
        do_reset();

        // null packet slot
        repeat (32) step(PER_DATA_ISLAND_ACTIVE);
        step(PER_CONTROL);

        // header-only packet
        offer_pkt(24'h0A0B0C, '0);
        step(PER_CONTROL);
        repeat (32) step(PER_DATA_ISLAND_ACTIVE);
        step(PER_CONTROL);

        // SP2 all ones
        b = '0;
        b[112 +: 56] = 56'hFF_FFFF_FFFF_FFFF;
        offer_pkt(24'h000000, b);
        step(PER_CONTROL);
        repeat (32) step(PER_DATA_ISLAND_ACTIVE);
        step(PER_CONTROL);

        // A buffered, B held until the consume, C offered mid-slot
        for (int it = 0; it < 4; it++) begin
            offer_pkt(24'($urandom), rnd_body());
            step(PER_CONTROL);
            offer_pkt(24'($urandom), rnd_body());
            step(PER_CONTROL);
            repeat (40) step(PER_DATA_ISLAND_ACTIVE);
            offer_pkt(24'($urandom), rnd_body());
            repeat (56) step(PER_DATA_ISLAND_ACTIVE);
            step(PER_CONTROL);
        end

        // abort at cnt 10 with a packet still buffered, then reset
        offer_pkt(24'($urandom), rnd_body());
        step(PER_CONTROL);
        offer_pkt(24'($urandom), rnd_body());
        repeat (10) step(PER_DATA_ISLAND_ACTIVE);
        step(PER_CONTROL);
        do_reset();
        repeat (32) step(PER_DATA_ISLAND_ACTIVE);
        step(PER_CONTROL);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/h14tx_data_island_packer.md
H14TX_DATA_ISLAND_PACKER -- requirements
Module: h14tx_data_island_packer

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset, ports as follows.
REQ-002 clk  input  1  pixel clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 period  input  period_t  current period from the timings block.
REQ-005 hsync  input  1  horizontal sync, same cycle as period.
REQ-006 vsync  input  1  vertical sync, same cycle as period.
REQ-007 pkt_valid  input  1  upstream offers a packet.
REQ-008 pkt_ready  output  1  block accepts the packet this cycle.
REQ-009 pkt_header  input  24  header bytes HB0..HB2, HB0 in bits [7:0].
REQ-010 pkt_body  input  224  subpackets SP0..SP3, 56 bits each; SPk in bits [56k+55:56k].
REQ-011 data  output  data_t [2:0]  4-bit data-island payload per TMDS channel, to the encoders.

Function
REQ-012 SHALL hold a single-entry packet buffer (header, body, full flag).
REQ-013 pkt_ready SHALL be !full || consume, where consume = (period == DataIslandActive) && (cnt == 0); a transfer occurs when pkt_valid && pkt_ready.
REQ-014 When a transfer and a consume occur in the same cycle, the buffer SHALL load the new packet and remain full.
REQ-015 cnt: 5-bit slot counter, +1 per cycle while period == DataIslandActive, wraps 31->0 (each 32-cycle slot carries one packet); forced to 0 when period != DataIslandActive.
REQ-016 At cnt == 0 the current packet SHALL be the buffer contents if full, otherwise the null packet (all-zero header and body); it is latched into active registers for cycles 1..31.
REQ-017 Cycle-0 output bits SHALL come directly from the buffer or null packet, with no extra latency: data is valid in the same cycle period indicates DataIslandActive.
REQ-018 data[0][0] = hsync and data[0][1] = vsync in every cycle.
REQ-019 data[0][3] SHALL be 0 when cnt == 0 and 1 otherwise during DataIslandActive.
REQ-020 data[0][2] SHALL be header bit cnt for cnt 0..23 and header ECC bit (cnt-24) for cnt 24..31.
REQ-021 data[1][k] and data[2][k] SHALL be SPk bits 2*cnt and 2*cnt+1 for cnt 0..27, and SPk ECC bits 2*(cnt-28) and 2*(cnt-28)+1 for cnt 28..31 (k = 0..3).
REQ-022 ECC SHALL be BCH with G(x)=1+x^6+x^7+x^8, computed serially LSB-first.
REQ-023 ECC update per input bit b: ecc_next = (ecc >> 1) ^ ((ecc[0] ^ b) ? 8'h83 : 8'h00); the register clears at the start of each slot.
REQ-024 Header ECC SHALL absorb 1 bit per cycle for cnt 0..23; each subpacket ECC SHALL absorb 2 bits per cycle (even bit first) for cnt 0..27; all ECC values are frozen for emission thereafter.
REQ-025 Outside DataIslandActive, data[0][3:2], data[1] and data[2] SHALL be 0.
REQ-026 A period exit mid-slot SHALL abort the packet (not retransmitted); cnt restarts at 0 on the next DataIslandActive.

Reset
REQ-027 While rst is high: full = 0, cnt = 0, active and ECC registers = 0, pkt_ready = 1, data[0][3:2] = 0, data[1] = 0, data[2] = 0.
REQ-028 Reset mid-slot SHALL discard both the buffered and the in-flight packet.

Verification
REQ-029 No packet offered, 32-cycle DataIslandActive -> null packet: data[1] = data[2] = 0, data[0][2] = 0 all cycles, data[0][3] = 0 at cycle 0 and 1 at cycles 1..31.
REQ-030 Header 24'h0A0B0C, body 0 -> data[0][2] at cycles 0..23 follows header LSB-first (cycle 2 = 1, cycle 3 = 1, cycle 0 = 0); cycles 24..31 match a software BCH model.
REQ-031 SP2 = 56'hFF_FFFF_FFFF_FFFF, other subpackets 0 -> data[1][2] = data[2][2] = 1 for cycles 0..27, ECC at 28..31 matches the model, and channel bits k != 2 stay 0.
REQ-032 64-cycle DataIslandActive, packet A buffered and packet B offered with pkt_valid held -> B accepted at cycle 0 together with the consume of A; A is sent in slot 0 and B in slot 1.
REQ-033 Period drops at cnt = 10, then rst is pulsed -> data[1], data[2] and data[0][3:2] go 0 immediately, pkt_ready = 1, and the next DataIslandActive sends the null packet.
